// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_slave
//  Description : Write-only I2C responder. Oversamples scl/sda on the system
//                clock and detects START/STOP. Matches a 7-bit address, ACKs
//                every received byte and presents it as a parallel word with
//                a one-clock strobe.
//  Options     : `define I2C_FILTER_EN adds a 3-sample glitch filter behind
//                each synchroniser. Every detection latency grows by 2 clk.
//  Ports       : clk        in    system clock, >= 8x scl frequency
//                reset      in    asynchronous active-low reset
//                scl        in    I2C clock (read only)
//                sda        inout I2C data, open drain (driven 0 or z only)
//                data_out   out   last received byte
//                data_valid out   1-clk pulse when data_out updates
//                busy       out   high from address ACK to STOP/repeated START
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_slave #(
    parameter int                    MESSAGE_LENGTH = 8,
    parameter int                    ADDR_WIDTH     = 7,
    parameter logic [ADDR_WIDTH-1:0] ADDRESS        = 7'h2A
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      scl,
    inout  wire                       sda,
    output logic [MESSAGE_LENGTH-1:0] data_out,
    output logic                      data_valid,
    output logic                      busy
);

    // The shift register holds either address + R/W or one data byte.
    localparam int SR_W  = (ADDR_WIDTH + 1 > MESSAGE_LENGTH) ? ADDR_WIDTH + 1 : MESSAGE_LENGTH;
    localparam int CNT_W = $clog2(SR_W + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(MESSAGE_LENGTH - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_DATA_ACK = 3'd4;
    localparam logic [2:0] S_IGNORE   = 3'd5;

    // ------------------------------------------------------------------
    // Input path: 2-FF synchronisers (idle-high reset so release of reset
    // cannot fake an edge), optional glitch filter, then a delayed copy.
    // ------------------------------------------------------------------
    logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
    logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
    logic scl_p_q,  scl_p_d,  sda_p_q,  sda_p_d;
    logic scl_f,    sda_f;

    always_comb begin
        scl_s1_d = scl;
        scl_s2_d = scl_s1_q;
        sda_s1_d = sda;
        sda_s2_d = sda_s1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_s1_d;
            scl_s2_q <= scl_s2_d;
            sda_s1_q <= sda_s1_d;
            sda_s2_q <= sda_s2_d;
        end
    end

`ifdef I2C_FILTER_EN
    // A line only changes once the current and the two previous synchronised
    // samples agree; the decision is combinational so the added delay is 2 clk.
    logic [1:0] scl_h_q, scl_h_d, sda_h_q, sda_h_d;
    logic       scl_fl_q, scl_fl_d, sda_fl_q, sda_fl_d;

    always_comb begin
        scl_h_d = {scl_h_q[0], scl_s2_q};
        sda_h_d = {sda_h_q[0], sda_s2_q};
        scl_f   = scl_fl_q;
        sda_f   = sda_fl_q;
        if ((scl_s2_q == scl_h_q[0]) && (scl_h_q[0] == scl_h_q[1])) begin
            scl_f = scl_s2_q;
        end
        if ((sda_s2_q == sda_h_q[0]) && (sda_h_q[0] == sda_h_q[1])) begin
            sda_f = sda_s2_q;
        end
        scl_fl_d = scl_f;
        sda_fl_d = sda_f;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_h_q  <= 2'b11;
            sda_h_q  <= 2'b11;
            scl_fl_q <= 1'b1;
            sda_fl_q <= 1'b1;
        end else begin
            scl_h_q  <= scl_h_d;
            sda_h_q  <= sda_h_d;
            scl_fl_q <= scl_fl_d;
            sda_fl_q <= sda_fl_d;
        end
    end
`else
    assign scl_f = scl_s2_q;
    assign sda_f = sda_s2_q;
`endif

    always_comb begin
        scl_p_d = scl_f;
        sda_p_d = sda_f;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_p_q <= 1'b1;
            sda_p_q <= 1'b1;
        end else begin
            scl_p_q <= scl_p_d;
            sda_p_q <= sda_p_d;
        end
    end

    logic scl_rise, scl_fall, bus_start, bus_stop;
    assign scl_rise  =  scl_f & ~scl_p_q;
    assign scl_fall  = ~scl_f &  scl_p_q;
    // scl must be high on both samples so an sda move that races a scl edge
    // is never taken as a bus condition.
    assign bus_start = scl_f & scl_p_q &  sda_p_q & ~sda_f;
    assign bus_stop  = scl_f & scl_p_q & ~sda_p_q &  sda_f;

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    logic [2:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SR_W-1:0]           sr_q, sr_d;
    logic                      ack_ph_q, ack_ph_d;   // 1 while sda is held for an ACK
    logic                      sda_oe_q, sda_oe_d;
    logic                      busy_q, busy_d;
    logic [MESSAGE_LENGTH-1:0] data_out_q, data_out_d;
    logic                      dv_q, dv_d;
    logic                      addr_match;

    // General call (all-zero address) and reads are never acknowledged.
    assign addr_match = (sr_q[ADDR_WIDTH:1] == ADDRESS) && !sr_q[0] &&
                        (sr_q[ADDR_WIDTH:1] != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        ack_ph_d   = ack_ph_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        data_out_d = data_out_q;
        dv_d       = 1'b0;

        if (bus_stop) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            ack_ph_d = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (bus_start) begin
            state_d  = S_ADDR;
            cnt_d    = '0;
            ack_ph_d = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sda_oe_d = 1'b0;
                end
                S_ADDR: begin
                    if (scl_rise) begin
                        sr_d = {sr_q[SR_W-2:0], sda_f};
                        if (cnt_q == ADDR_LAST) begin
                            cnt_d   = '0;
                            state_d = S_ADDR_ACK;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                // First falling edge ends bit 8 (start of ACK slot), the
                // second ends the ACK slot.
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_ph_q) begin
                            if (addr_match) begin
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                                ack_ph_d = 1'b1;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end else begin
                            sda_oe_d = 1'b0;
                            ack_ph_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (scl_rise) begin
                        sr_d = {sr_q[SR_W-2:0], sda_f};
                        if (cnt_q == DATA_LAST) begin
                            cnt_d   = '0;
                            state_d = S_DATA_ACK;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_DATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_ph_q) begin
                            data_out_d = sr_q[MESSAGE_LENGTH-1:0];
                            dv_d       = 1'b1;
                            sda_oe_d   = 1'b1;
                            ack_ph_d   = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            ack_ph_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = S_DATA;
                        end
                    end
                end
                S_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    ack_ph_d = 1'b0;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            ack_ph_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            data_out_q <= '0;
            dv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            ack_ph_q   <= ack_ph_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            data_out_q <= data_out_d;
            dv_q       <= dv_d;
        end
    end

    assign sda        = sda_oe_q ? 1'b0 : 1'bz;
    assign data_out   = data_out_q;
    assign data_valid = dv_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_i2c_slave
//  Description : Self-checking bench for i2c_slave. A bus-master model drives
//                scl/sda; expected bytes go into a scoreboard queue when they
//                are sent and are popped when data_valid fires.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_slave;

    localparam int Q = 6;  // quarter scl period in clk cycles

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       scl     = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda_bus;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic       dv_prev = 1'b0;
    logic       ack;

    pullup (sda_bus);
    assign sda_bus = sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave dut (
        .clk        (clk),
        .reset      (reset),
        .scl        (scl),
        .sda        (sda_bus),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every strobe must match the oldest queued byte.
    always @(negedge clk) begin
        if (data_valid) begin
            check("dv_width", {31'd0, dv_prev}, 32'd0);
            check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                check("sb_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
        end
        dv_prev <= data_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    // Works from idle (scl high) and as a repeated START (scl low).
    task automatic i2c_start();
        sda_low = 1'b0; wait_q();
        scl = 1'b1;     wait_q();
        sda_low = 1'b1; wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; wait_q();
        scl = 1'b1;     wait_q();
        sda_low = 1'b0; wait_q();
        wait_q();
    endtask

    task automatic put_bit(input logic b, input logic glitch);
        sda_low = ~b; wait_q();
        scl = 1'b1;   wait_q();
        if (glitch) begin
            sda_low = ~sda_low; @(negedge clk);
            sda_low = ~sda_low; repeat (Q - 1) @(negedge clk);
        end else begin
            wait_q();
        end
        scl = 1'b0;   wait_q();
    endtask

    task automatic get_ack(output logic a);
        sda_low = 1'b0; wait_q();
        scl = 1'b1;     wait_q();
        a = sda_bus;    wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic a);
        for (int i = 7; i >= 0; i--) put_bit(b[i], i == glitch_bit);
        get_ack(a);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_dv", {31'd0, data_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sda", {31'd0, sda_bus}, 32'd1);
        reset = 1'b1;
        wait_q();

        // 1: addressed write of one byte
        i2c_start();
        send_byte({7'h2A, 1'b0}, -1, ack);
        check("t1_addr_ack", {31'd0, ack}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back(8'h5F);
        send_byte(8'h5F, -1, ack);
        check("t1_data_ack", {31'd0, ack}, 32'd0);
        check("t1_busy_hold", {31'd0, busy}, 32'd1);
        i2c_stop();
        check("t1_busy_stop", {31'd0, busy}, 32'd0);
        check("t1_data_out", {24'd0, data_out}, 32'h5F);

        // 2: foreign address is ignored up to STOP
        i2c_start();
        send_byte({7'h15, 1'b0}, -1, ack);
        check("t2_addr_nack", {31'd0, ack}, 32'd1);
        check("t2_busy", {31'd0, busy}, 32'd0);
        send_byte(8'hAA, -1, ack);
        check("t2_data_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check("t2_data_out", {24'd0, data_out}, 32'h5F);

        // 3: three bytes in one transfer
        i2c_start();
        send_byte({7'h2A, 1'b0}, -1, ack);
        check("t3_addr_ack", {31'd0, ack}, 32'd0);
        foreach (exp_q[i]) begin end
        begin
            logic [7:0] bytes [3];
            bytes = '{8'h95, 8'hF0, 8'h0F};
            for (int i = 0; i < 3; i++) begin
                exp_q.push_back(bytes[i]);
                send_byte(bytes[i], -1, ack);
                check("t3_data_ack", {31'd0, ack}, 32'd0);
            end
        end
        i2c_stop();
        check("t3_data_out", {24'd0, data_out}, 32'h0F);

        // 4a: STOP after four data bits discards the partial byte
        i2c_start();
        send_byte({7'h2A, 1'b0}, -1, ack);
        check("t4a_addr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 4; i++) put_bit(i[0], 1'b0);
        i2c_stop();
        check("t4a_busy", {31'd0, busy}, 32'd0);
        check("t4a_data_out", {24'd0, data_out}, 32'h0F);

        // 4b: repeated START mid-byte, then a fresh one-byte write
        i2c_start();
        send_byte({7'h2A, 1'b0}, -1, ack);
        for (int i = 0; i < 4; i++) put_bit(~i[0], 1'b0);
        i2c_start();
        check("t4b_busy_rs", {31'd0, busy}, 32'd0);
        send_byte({7'h2A, 1'b0}, -1, ack);
        check("t4b_addr_ack", {31'd0, ack}, 32'd0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, -1, ack);
        check("t4b_data_ack", {31'd0, ack}, 32'd0);
        i2c_stop();

        // 5: reset in the middle of a data byte
        i2c_start();
        send_byte({7'h2A, 1'b0}, -1, ack);
        for (int i = 0; i < 3; i++) put_bit(1'b1, 1'b0);
        sda_low = 1'b0;
        reset = 1'b0;
        #1;
        check("t5_rst_sda", {31'd0, sda_bus}, 32'd1);
        check("t5_rst_data_out", {24'd0, data_out}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_dv", {31'd0, data_valid}, 32'd0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        i2c_start();
        send_byte({7'h2A, 1'b0}, -1, ack);
        check("t5_addr_ack", {31'd0, ack}, 32'd0);
        exp_q.push_back(8'hA7);
        send_byte(8'hA7, -1, ack);
        check("t5_data_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("t5_data_out", {24'd0, data_out}, 32'hA7);

        // 6: read request is NACKed and the rest ignored
        i2c_start();
        send_byte({7'h2A, 1'b1}, -1, ack);
        check("t6_read_nack", {31'd0, ack}, 32'd1);
        check("t6_busy", {31'd0, busy}, 32'd0);
        send_byte(8'h55, -1, ack);
        check("t6_data_nack", {31'd0, ack}, 32'd1);
        i2c_stop();

        // General call is NACKed
        i2c_start();
        send_byte({7'h00, 1'b0}, -1, ack);
        check("gc_nack", {31'd0, ack}, 32'd1);
        i2c_stop();

`ifdef I2C_FILTER_EN
        // A 1-clk sda glitch while scl is high must not break the byte
        i2c_start();
        send_byte({7'h2A, 1'b0}, -1, ack);
        check("flt_addr_ack", {31'd0, ack}, 32'd0);
        exp_q.push_back(8'h96);
        send_byte(8'h96, 3, ack);
        check("flt_data_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
`endif

        wait_q();
        check("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
